gpio_pixel_receiver: RTL and testbench

- Receiving end of the processor's GPIO output interface.
- Captures 32-bit GPIO words strobed per colour channel (GPIOEnR/G/B), each holding 4 packed 8-bit channel samples, and assembles them into 4 RGB pixels.
- Streams the pixels with sequential frame addresses to a frame-buffer writer over a valid/ready handshake.
- Control words on GPIOEn start frames; frame completion and overrun status are reported.

---
 rtl/gpio_pixel_receiver_if.sv | 24 ++
 rtl/gpio_pixel_receiver.sv | 147 ++++++++++++++
 tb/tb_gpio_pixel_receiver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pixel_receiver_if.sv
// Pixel stream between the GPIO pixel receiver and a frame-buffer writer.
// The receiver drives valid/address/data; the writer drives ready.
interface gpio_pixel_receiver_if #(
    parameter int ADDR_W = 16
);
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;

    modport master (
        output pix_valid,
        output pix_addr,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_addr,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/gpio_pixel_receiver.sv
// GPIO pixel receiver: gathers R/G/B GPIO words (4 packed samples each) into a
// capture group, hands complete groups to a 4-pixel emit buffer, and streams
// the pixels with wrapping frame addresses over a valid/ready handshake.
module gpio_pixel_receiver #(
    parameter int ADDR_W       = 16,
    parameter int FRAME_PIXELS = 65536
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  GPIO,
    input  logic                         GPIOEnR,
    input  logic                         GPIOEnG,
    input  logic                         GPIOEnB,
    input  logic                         GPIOEn,
    gpio_pixel_receiver_if.master        pix,
    output logic                         frame_done,
    output logic                         overflow,
    output logic                         busy
);

    typedef enum logic {S_EMPTY, S_EMIT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Channel index: 0 = R, 1 = G, 2 = B.
    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        flag_q, flag_d;
    logic [31:0]       cap_q [3];
    logic [31:0]       cap_d [3];
    logic [31:0]       buf_q [3];
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic [2:0] stb;
    logic [2:0] stb_eff;
    logic [2:0] flag_cur;
    logic       start;
    logic       drop;
    logic       complete;
    logic       accept;
    logic       load;
    logic [4:0] sel;

    assign stb   = {GPIOEnB, GPIOEnG, GPIOEnR};
    assign start = GPIOEn & GPIO[0];

    // A full group waiting behind an occupied emit buffer has nowhere to go,
    // so any new channel strobe is discarded rather than corrupting it.
    assign drop     = !start && (&flag_q) && (state_q == S_EMIT) && (|stb);
    assign stb_eff  = drop ? 3'b000 : stb;
    // Start clears the group first; same-cycle strobes land in the fresh group.
    assign flag_cur = (start ? 3'b000 : flag_q) | stb_eff;
    assign complete = &flag_cur;
    assign accept   = (state_q == S_EMIT) && pix.pix_ready;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            // Capture register: every strobed channel takes the current word.
            assign cap_d[gi] = stb_eff[gi] ? GPIO : cap_q[gi];

            // Capture and emit-buffer storage for one colour channel.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cap_q[gi] <= '0;
                    buf_q[gi] <= '0;
                end else begin
                    cap_q[gi] <= cap_d[gi];
                    if (start) begin
                        buf_q[gi] <= '0;
                    end else if (load) begin
                        buf_q[gi] <= cap_d[gi];
                    end
                end
            end
        end
    endgenerate

    // Next-state logic for the emit FSM, address counter and status flags.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        flag_d       = flag_cur;
        frame_done_d = frame_done_q;
        overflow_d   = overflow_q | drop;
        load         = 1'b0;
        if (start) begin
            state_d      = S_EMPTY;
            idx_d        = 2'd0;
            addr_d       = '0;
            frame_done_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            if (accept) begin
                idx_d = idx_q + 2'd1;
                if (addr_q == LAST_ADDR) begin
                    addr_d       = '0;
                    frame_done_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            // Buffer free now (empty, or last pixel leaving): refill without a bubble.
            if ((state_q == S_EMPTY) || (accept && (idx_q == 2'd3))) begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = S_EMIT;
                    idx_d   = 2'd0;
                    flag_d  = 3'b000;
                end else begin
                    state_d = S_EMPTY;
                end
            end
        end
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_EMPTY;
            idx_q        <= 2'd0;
            addr_q       <= '0;
            flag_q       <= 3'b000;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            flag_q       <= flag_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sel           = {idx_q, 3'b000};
    assign pix.pix_valid = (state_q == S_EMIT);
    assign pix.pix_addr  = addr_q;
    assign pix.pix_data  = {buf_q[0][sel +: 8], buf_q[1][sel +: 8], buf_q[2][sel +: 8]};
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;
    assign busy          = (|flag_q) || (state_q == S_EMIT);

endmodule

// File: tb/tb_gpio_pixel_receiver.sv
// Scoreboard bench for gpio_pixel_receiver (FRAME_PIXELS = 8 to exercise wrap).
module tb_gpio_pixel_receiver;
    localparam int FP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] GPIO = '0;
    logic        GPIOEnR = 1'b0;
    logic        GPIOEnG = 1'b0;
    logic        GPIOEnB = 1'b0;
    logic        GPIOEn  = 1'b0;
    logic        frame_done;
    logic        overflow;
    logic        busy;

    gpio_pixel_receiver_if #(.ADDR_W(16)) pif ();

    gpio_pixel_receiver #(
        .ADDR_W       (16),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .GPIO       (GPIO),
        .GPIOEnR    (GPIOEnR),
        .GPIOEnG    (GPIOEnG),
        .GPIOEnB    (GPIOEnB),
        .GPIOEn     (GPIOEn),
        .pix        (pif),
        .frame_done (frame_done),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [39:0] exp_q[$];      // {addr[15:0], rgb[23:0]}
    int          exp_cnt = 0;
    int          beats = 0;
    logic        exp_fd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_group(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({16'(exp_cnt), r[8*i +: 8], g[8*i +: 8], b[8*i +: 8]});
            exp_cnt = (exp_cnt + 1) % FP;
        end
    endtask

    task automatic drive(input logic r, input logic g, input logic b, input logic c,
                         input logic [31:0] w);
        GPIO = w; GPIOEnR = r; GPIOEnG = g; GPIOEnB = b; GPIOEn = c;
        @(posedge clk);
        #1;
        GPIO = '0; GPIOEnR = 1'b0; GPIOEnG = 1'b0; GPIOEnB = 1'b0; GPIOEn = 1'b0;
    endtask

    task automatic do_start();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
        exp_q.delete();
        exp_cnt = 0;
        exp_fd  = 1'b0;
    endtask

    task automatic group_all(input logic [31:0] w);
        drive(1'b1, 1'b1, 1'b1, 1'b0, w);
        push_group(w, w, w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every valid cycle must show the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            if (pif.pix_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {31'd0, pif.pix_valid}, 32'd0);
                end else begin
                    chk("pix_addr", {16'd0, pif.pix_addr}, {16'd0, exp_q[0][39:24]});
                    chk("pix_data", {8'd0, pif.pix_data}, {8'd0, exp_q[0][23:0]});
                    if (pif.pix_ready) begin
                        if (exp_q[0][39:24] == 16'(FP - 1)) exp_fd = 1'b1;
                        void'(exp_q.pop_front());
                        beats++;
                        $display("beat addr=%0d data=%06h", pif.pix_addr, pif.pix_data);
                    end
                end
            end
        end
    end

    initial begin
        int b0;
        pif.pix_ready = 1'b0;
        idle(2);
        chk("rst_valid", {31'd0, pif.pix_valid}, 32'd0);
        chk("rst_addr", {16'd0, pif.pix_addr}, 32'd0);
        chk("rst_data", {8'd0, pif.pix_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        idle(1);

        // Separate R/G/B strobes, sink always ready.
        do_start();
        pif.pix_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h4433_2211);
        chk("busy_partial", {31'd0, busy}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h8877_6655);
        chk("lat_pre", {31'd0, pif.pix_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hCCBB_AA99);
        push_group(32'h4433_2211, 32'h8877_6655, 32'hCCBB_AA99);
        chk("lat_post", {31'd0, pif.pix_valid}, 32'd1);
        idle(6);
        chk("t1_idle", {31'd0, pif.pix_valid}, 32'd0);

        // All three channels at once, sink stalled 5 cycles; inert control word.
        pif.pix_ready = 1'b0;
        group_all(32'h0102_0304);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        idle(2);
        chk("stall_valid", {31'd0, pif.pix_valid}, 32'd1);
        pif.pix_ready = 1'b1;
        idle(6);

        // Second group completes during emission: 8 beats with no bubble.
        do_start();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1312_1110);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h2322_2120);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h3332_3130);
        push_group(32'h1312_1110, 32'h2322_2120, 32'h3332_3130);
        b0 = beats;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h4342_4140);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h5352_5150);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h6362_6160);
        push_group(32'h4342_4140, 32'h5352_5150, 32'h6362_6160);
        idle(5);
        chk("b2b_beats", 32'(beats - b0), 32'd8);
        chk("fd_after8", {31'd0, frame_done}, 32'd1);
        idle(2);

        // Overrun: two groups queued behind a stalled sink, then a stray R.
        do_start();
        pif.pix_ready = 1'b0;
        group_all(32'hA3A2_A1A0);
        group_all(32'hB3B2_B1B0);
        chk("ovf_pre", {31'd0, overflow}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        pif.pix_ready = 1'b1;
        idle(10);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Frame wrap: three groups -> addr 0..7, 0..3; start clears frame_done.
        do_start();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        group_all(32'hC3C2_C1C0);
        idle(3);
        group_all(32'hD3D2_D1D0);
        idle(3);
        group_all(32'hE3E2_E1E0);
        idle(6);
        chk("fd_wrap", {31'd0, frame_done}, 32'd1);
        do_start();
        chk("fd_clear", {31'd0, frame_done}, 32'd0);
        group_all(32'hF3F2_F1F0);
        idle(6);

        // Abort by start while beat 2 is on the bus.
        do_start();
        group_all(32'h5A5B_5C5D);
        idle(1);
        do_start();
        chk("abort_valid", {31'd0, pif.pix_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        idle(2);

        // Asynchronous reset in the middle of a stalled beat.
        pif.pix_ready = 1'b0;
        group_all(32'h7172_7374);
        idle(1);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        exp_fd  = 1'b0;
        chk("arst_valid", {31'd0, pif.pix_valid}, 32'd0);
        chk("arst_data", {8'd0, pif.pix_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pif.pix_ready = 1'b1;
        idle(4);
        chk("post_rst_valid", {31'd0, pif.pix_valid}, 32'd0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
